instr_encoder: RTL

Sequential instruction encoder (the write-side counterpart of the control decoder) for the single-cycle ARM core with the vector/FP extensions.
Accepts one symbolic instruction per valid/ready handshake and emits a 32-bit word: cond[31:28], op[27:26], funct[25:20], Rn[19:16], Rd[15:12], src2[11:0].
Writes each word sequentially into instruction memory through a write port.
Used by the boot/program loader and by testbenches to build programs that the decoder consumes.

---
 rtl/instr_encoder_pkg.sv | 47 ++++
 rtl/instr_encoder_if.sv | 41 ++++
 rtl/instr_encoder_imm_rot_check.sv | 16 +
 rtl/instr_encoder.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared encodings for the instruction encoder: class/op/cmd codes matching the
// control decoder table, error codes and the encoder FSM state type.
package instr_pkg;

  localparam logic [1:0] CLS_DP_REG = 2'd0;
  localparam logic [1:0] CLS_DP_IMM = 2'd1;
  localparam logic [1:0] CLS_MEM    = 2'd2;
  localparam logic [1:0] CLS_BRANCH = 2'd3;

  localparam logic [1:0] OP_DP     = 2'b00;
  localparam logic [1:0] OP_MEM    = 2'b01;
  localparam logic [1:0] OP_BRANCH = 2'b10;

  localparam logic [3:0] CMD_ORR    = 4'b0000;
  localparam logic [3:0] CMD_AND    = 4'b0010;
  localparam logic [3:0] CMD_XOR    = 4'b0011;
  localparam logic [3:0] CMD_ADD    = 4'b0100;
  localparam logic [3:0] CMD_SUB    = 4'b0101;
  localparam logic [3:0] CMD_FMUL   = 4'b0110;
  localparam logic [3:0] CMD_FADD   = 4'b0111;
  localparam logic [3:0] CMD_VADD   = 4'b1000;
  localparam logic [3:0] CMD_VSUB   = 4'b1001;
  localparam logic [3:0] CMD_VAND   = 4'b1010;
  localparam logic [3:0] CMD_VORR   = 4'b1011;
  localparam logic [3:0] CMD_VADDFP = 4'b1100;
  localparam logic [3:0] CMD_MOVIDX = 4'b1101;
  localparam logic [3:0] CMD_MOV    = 4'b1110;
  localparam logic [3:0] CMD_VXOR   = 4'b1111;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_IMM   = 2'd1;
  localparam logic [1:0] ERR_REG   = 2'd2;
  localparam logic [1:0] ERR_RANGE = 2'd3;

  localparam logic [5:0] FUNCT_LDR   = 6'b011001;
  localparam logic [5:0] FUNCT_STR   = 6'b011000;
  localparam logic [1:0] BR_FUNCT_HI = 2'b10;
  localparam logic [31:0] MEM_OFS_MAX = 32'd4095;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_WRITE  = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

endpackage

// File: rtl/instr_encoder_if.sv
// Request handshake, instruction-memory write port and status of the encoder.
interface instr_encoder_if #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 64
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_class;
  logic [3:0]        in_cmd;
  logic              in_s;
  logic              in_load;
  logic [3:0]        in_cond;
  logic [3:0]        in_rd;
  logic [3:0]        in_rn;
  logic [3:0]        in_rm;
  logic [31:0]       in_imm;
  logic [31:0]       in_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              err_valid;
  logic [1:0]        err_code;
  logic [CW-1:0]     count;
  logic              full;

  modport master (
    output in_valid, in_class, in_cmd, in_s, in_load, in_cond,
           in_rd, in_rn, in_rm, in_imm, in_target,
    input  in_ready, imem_we, imem_addr, imem_wdata, err_valid, err_code,
           count, full
  );

  modport slave (
    input  in_valid, in_class, in_cmd, in_s, in_load, in_cond,
           in_rd, in_rn, in_rm, in_imm, in_target,
    output in_ready, imem_we, imem_addr, imem_wdata, err_valid, err_code,
           count, full
  );
endinterface

// File: rtl/instr_encoder_imm_rot_check.sv
// Tests whether imm rotated left by 2*rot fits in 8 bits (ARM rotated-immediate form).
module imm_rot_check (
  input  logic [31:0] imm,
  input  logic [3:0]  rot,
  output logic        hit,
  output logic [7:0]  imm8
);
  logic [63:0] dbl;
  logic [31:0] rotated;

  // Upper half of the shifted doubled word is the left rotation.
  assign dbl     = {imm, imm} << {rot, 1'b0};
  assign rotated = dbl[63:32];
  assign hit     = (rotated[31:8] == 24'h0);
  assign imm8    = rotated[7:0];
endmodule

// File: rtl/instr_encoder.sv
// Sequential instruction encoder: one symbolic request per handshake, one
// 32-bit word written to instruction memory at consecutive addresses.
//
// state  | meaning
// IDLE   | ready for a request (unless full)
// SEARCH | trying one immediate rotation per cycle, smallest first
// WRITE  | imem_we high, word and address on the write port
// ERR    | err_valid pulse, request dropped
module instr_encoder
  import instr_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                DEPTH     = 64
) (
  input logic            clk,
  input logic            reset,
  instr_encoder_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  state_t            state, state_nxt;
  logic [1:0]        cls_q, err_code_q, err_nxt;
  logic [3:0]        cmd_q, cond_q, rd_q, rn_q, rm_q, rot_q;
  logic              s_q, load_q;
  logic [31:0]       imm_q, target_q, br_diff, word;
  logic [11:0]       src2_q;
  logic [CW-1:0]     count_q;
  logic [ADDR_W-1:0] addr_q;
  logic              accept, hit, full;
  logic [7:0]        imm8;
  logic              unused_diff;

  imm_rot_check u_rot (.imm(imm_q), .rot(rot_q), .hit(hit), .imm8(imm8));

  assign full         = (count_q == CW'(DEPTH));
  assign bus.in_ready = (state == ST_IDLE) && !full && !reset;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    state_nxt = state;
    err_nxt   = err_code_q;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_WRITE;
          case (bus.in_class)
            CLS_DP_IMM: state_nxt = ST_SEARCH;
            // MOV/MOVIDX in register form decode as vector-register ops.
            CLS_DP_REG: begin
              if (bus.in_cmd == CMD_MOV || bus.in_cmd == CMD_MOVIDX) begin
                state_nxt = ST_ERR;
                err_nxt   = ERR_REG;
              end
            end
            CLS_MEM: begin
              if (bus.in_imm > MEM_OFS_MAX) begin
                state_nxt = ST_ERR;
                err_nxt   = ERR_RANGE;
              end
            end
            default: begin
              if (bus.in_target[1:0] != 2'b00) begin
                state_nxt = ST_ERR;
                err_nxt   = ERR_RANGE;
              end
            end
          endcase
        end
      end
      ST_SEARCH: begin
        if (hit) begin
          state_nxt = ST_WRITE;
        end else if (rot_q == 4'hF) begin
          state_nxt = ST_ERR;
          err_nxt   = ERR_IMM;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      err_code_q <= ERR_NONE;
      cls_q      <= '0;
      cmd_q      <= '0;
      s_q        <= 1'b0;
      load_q     <= 1'b0;
      cond_q     <= '0;
      rd_q       <= '0;
      rn_q       <= '0;
      rm_q       <= '0;
      imm_q      <= '0;
      target_q   <= '0;
      rot_q      <= '0;
      src2_q     <= '0;
      count_q    <= '0;
      addr_q     <= BASE_ADDR;
    end else begin
      state      <= state_nxt;
      err_code_q <= err_nxt;
      if (accept) begin
        cls_q    <= bus.in_class;
        cmd_q    <= bus.in_cmd;
        s_q      <= bus.in_s;
        load_q   <= bus.in_load;
        cond_q   <= bus.in_cond;
        rd_q     <= bus.in_rd;
        rn_q     <= bus.in_rn;
        rm_q     <= bus.in_rm;
        imm_q    <= bus.in_imm;
        target_q <= bus.in_target;
        rot_q    <= '0;
      end
      if (state == ST_SEARCH) begin
        if (hit) src2_q <= {rot_q, imm8};
        else     rot_q  <= rot_q + 4'd1;
      end
      if (state == ST_WRITE) begin
        count_q <= count_q + CW'(1);
        addr_q  <= addr_q + ADDR_W'(4);
      end
    end
  end

  // Branch offset is relative to the word's own address plus 8 (pipeline PC).
  assign br_diff     = target_q - (32'(addr_q) + 32'd8);
  assign unused_diff = ^{br_diff[31:26], br_diff[1:0]};

  always_comb begin
    word = '0;
    case (cls_q)
      CLS_DP_REG: word = {cond_q, OP_DP, 1'b0, cmd_q, s_q, rn_q, rd_q, 8'h00, rm_q};
      CLS_DP_IMM: word = {cond_q, OP_DP, 1'b1, cmd_q, s_q, rn_q, rd_q, src2_q};
      CLS_MEM:    word = {cond_q, OP_MEM, (load_q ? FUNCT_LDR : FUNCT_STR), rn_q, rd_q, imm_q[11:0]};
      default:    word = {cond_q, OP_BRANCH, BR_FUNCT_HI, br_diff[25:2]};
    endcase
  end

  assign bus.imem_we    = (state == ST_WRITE);
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = word;
  assign bus.err_valid  = (state == ST_ERR);
  assign bus.err_code   = err_code_q;
  assign bus.count      = count_q;
  assign bus.full       = full;
endmodule
